// File: rtl/seg_led_output.sv
// seg_led_output: CPU-writable output peripheral.
// Holds a 24-bit LED register, a 32-bit (8 x hex digit) display register and a
// digit mask, and time-multiplexes an 8-digit common-anode 7-segment display.
// Each digit slot starts with a short all-off window to suppress ghosting.
module seg_led_output #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        SegCtrl,
   input  logic        ioWrite,
   input  logic [2:0]  segAddr,
   input  logic [15:0] write_data,
   output logic [23:0] leds,
   output logic [7:0]  seg_out,
   output logic [7:0]  seg_en
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         4'hF:    pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   logic [23:0]   led_r;
   logic [31:0]   disp_r;
   logic [7:0]    mask_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    idx_r;
   logic [7:0]    seg_en_r;
   logic [7:0]    seg_out_r;

   logic          wr_en_s;
   logic [3:0]    digit_s;
   logic          blank_s;
   logic [7:0]    seg_en_s;
   logic [7:0]    seg_out_s;

   assign wr_en_s = SegCtrl & ioWrite;

   // CPU register file: LED halves, display halves and digit mask.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_r  <= 24'h00_0000;
         disp_r <= 32'h0000_0000;
         mask_r <= 8'hFF;
      end else if (wr_en_s) begin
         case (segAddr)
            3'b000:  led_r[15:0]   <= write_data;
            3'b010:  led_r[23:16]  <= write_data[7:0];
            3'b100:  disp_r[15:0]  <= write_data;
            3'b110:  disp_r[31:16] <= write_data;
            3'b001:  mask_r        <= write_data[7:0];
            default: led_r         <= led_r;
         endcase
      end else begin
         led_r <= led_r;
      end
   end

   // Free-running slot counter and digit index; bus writes never disturb it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
         idx_r <= 3'd0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= {CW{1'b0}};
         idx_r <= idx_r + 3'd1;
      end else begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Select the nibble belonging to the digit currently being scanned.
   always_comb begin
      digit_s = 4'h0;
      case (idx_r)
         3'd0:    digit_s = disp_r[3:0];
         3'd1:    digit_s = disp_r[7:4];
         3'd2:    digit_s = disp_r[11:8];
         3'd3:    digit_s = disp_r[15:12];
         3'd4:    digit_s = disp_r[19:16];
         3'd5:    digit_s = disp_r[23:20];
         3'd6:    digit_s = disp_r[27:24];
         3'd7:    digit_s = disp_r[31:28];
         default: digit_s = 4'h0;
      endcase
   end

   // Next display drive: dark during the blanking window or for masked digits.
   always_comb begin
      blank_s   = (cnt_r < CNT_BLANK) | ~mask_r[idx_r];
      seg_en_s  = 8'hFF;
      seg_out_s = 8'hFF;
      if (blank_s) begin
         seg_en_s  = 8'hFF;
         seg_out_s = 8'hFF;
      end else begin
         seg_en_s  = ~(8'b0000_0001 << idx_r);
         seg_out_s = {1'b1, hex7(digit_s)};
      end
   end

   // Display outputs are registered so the pins never see decode glitches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_en_r  <= 8'hFF;
         seg_out_r <= 8'hFF;
      end else begin
         seg_en_r  <= seg_en_s;
         seg_out_r <= seg_out_s;
      end
   end

   assign leds    = led_r;
   assign seg_en  = seg_en_r;
   assign seg_out = seg_out_r;

endmodule

// File: tb/tb_seg_led_output.sv
// Self-checking bench for seg_led_output with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_led_output;

   localparam int SD = 8;
   localparam int BC = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        SegCtrl = 1'b0;
   logic        ioWrite = 1'b0;
   logic [2:0]  segAddr = 3'd0;
   logic [15:0] write_data = 16'h0000;
   logic [23:0] leds;
   logic [7:0]  seg_out;
   logic [7:0]  seg_en;

   seg_led_output #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clock(clock), .reset(reset), .SegCtrl(SegCtrl), .ioWrite(ioWrite),
      .segAddr(segAddr), .write_data(write_data),
      .leds(leds), .seg_out(seg_out), .seg_en(seg_en)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [7:0] EXP1 [11] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                             8'hFF, 8'hFF, 8'hFD};
   logic [7:0] T2 [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};

   typedef struct {
      logic [23:0] leds;
      logic [7:0]  en;
      logic [7:0]  out;
   } exp_t;
   exp_t sb_q [$];

   typedef struct {
      logic        ctrl;
      logic        iow;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [23:0] exp_leds;
   } vec_t;
   vec_t vecs [7];

   // reference model state
   logic [23:0] m_led;
   logic [31:0] m_disp;
   logic [7:0]  m_mask;
   int          m_cnt;
   int          m_idx;
   int          cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_led  = 24'h0;
      m_disp = 32'h0;
      m_mask = 8'hFF;
      m_cnt  = 0;
      m_idx  = 0;
      sb_q.delete();
   endtask

   // predict the outputs produced by the coming edge and push them to the scoreboard
   task automatic model_step();
      exp_t e;
      if (m_cnt < BC || m_mask[m_idx] == 1'b0) begin
         e.en  = 8'hFF;
         e.out = 8'hFF;
      end else begin
         e.en  = ~(8'b0000_0001 << m_idx);
         e.out = HEX[m_disp[4*m_idx +: 4]];
      end
      if (SegCtrl && ioWrite) begin
         case (segAddr)
            3'b000:  m_led[15:0]   = write_data;
            3'b010:  m_led[23:16]  = write_data[7:0];
            3'b100:  m_disp[15:0]  = write_data;
            3'b110:  m_disp[31:16] = write_data;
            3'b001:  m_mask        = write_data[7:0];
            default: ;
         endcase
      end
      if (m_cnt == SD - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % 8;
      end else begin
         m_cnt = m_cnt + 1;
      end
      e.leds = m_led;
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clock);
      #1;
      cyc++;
      e = sb_q.pop_front();
      check("leds", {8'h0, leds}, {8'h0, e.leds});
      check("seg_en", {24'h0, seg_en}, {24'h0, e.en});
      check("seg_out", {24'h0, seg_out}, {24'h0, e.out});
      check("en_onehot", {31'h0, ($countones(~seg_en) <= 1)}, 32'h1);
   endtask

   task automatic idle();
      SegCtrl = 1'b0; ioWrite = 1'b0; segAddr = 3'd0; write_data = 16'h0000;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      SegCtrl = 1'b1; ioWrite = 1'b1; segAddr = a; write_data = d;
      cycle();
      idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_seg_en", {24'h0, seg_en}, 32'h0000_00FF);
      check("rst_seg_out", {24'h0, seg_out}, 32'h0000_00FF);
      check("rst_leds", {8'h0, leds}, 32'h0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // wait (bounded) for seg_en to newly become target
   task automatic wait_start(input logic [7:0] target, input int budget, output bit found);
      logic [7:0] prev;
      found = 1'b0;
      prev = seg_en;
      for (int i = 0; i < budget && !found; i++) begin
         cycle();
         if (seg_en == target && prev != target) found = 1'b1;
         prev = seg_en;
      end
   endtask

   task automatic check_post_reset(input string tag);
      for (int i = 0; i < 11; i++) begin
         cycle();
         check({tag, "_en"}, {24'h0, seg_en}, {24'h0, EXP1[i]});
         if (EXP1[i] != 8'hFF) check({tag, "_out"}, {24'h0, seg_out}, 32'h0000_00C0);
      end
   endtask

   initial begin
      bit          found;
      logic [7:0]  prev_en;
      logic [15:0] cap [$];
      int          starts [$];
      int          dark_hits;
      int          i0;

      idle();
      #2;
      do_reset();

      // 1: reset release timing
      check_post_reset("t1");

      // 2: digit values over a full scan
      bus_write(3'b100, 16'h1234);
      bus_write(3'b110, 16'hABCD);
      prev_en = seg_en;
      for (int i = 0; i < 160; i++) begin
         cycle();
         if (seg_en != 8'hFF && seg_en != prev_en) cap.push_back({seg_en, seg_out});
         prev_en = seg_en;
      end
      i0 = -1;
      for (int i = 0; i < cap.size(); i++) if (i0 < 0 && cap[i][15:8] == 8'hFE) i0 = i;
      if (i0 < 0 || i0 + 9 > cap.size()) begin
         check("t2_capture_len", cap.size(), i0 + 9);
      end else begin
         for (int k = 0; k < 9; k++) begin
            check("t2_en", {24'h0, cap[i0+k][15:8]}, {24'h0, ~(8'b0000_0001 << (k % 8))});
            check("t2_out", {24'h0, cap[i0+k][7:0]}, {24'h0, T2[k % 8]});
         end
      end

      // 3: LED register writes, table driven
      vecs[0] = '{1'b1, 1'b1, 3'b000, 16'hBEEF, 24'h00BEEF};
      vecs[1] = '{1'b1, 1'b1, 3'b010, 16'h00A5, 24'hA5BEEF};
      vecs[2] = '{1'b0, 1'b1, 3'b000, 16'h1111, 24'hA5BEEF};
      vecs[3] = '{1'b1, 1'b0, 3'b010, 16'h0022, 24'hA5BEEF};
      vecs[4] = '{1'b1, 1'b1, 3'b011, 16'hFFFF, 24'hA5BEEF};
      vecs[5] = '{1'b1, 1'b1, 3'b111, 16'h5555, 24'hA5BEEF};
      vecs[6] = '{1'b1, 1'b1, 3'b010, 16'hFF34, 24'h34BEEF};
      for (int i = 0; i < 7; i++) begin
         SegCtrl = vecs[i].ctrl; ioWrite = vecs[i].iow;
         segAddr = vecs[i].addr; write_data = vecs[i].data;
         cycle();
         idle();
         check("t3_leds", {8'h0, leds}, {8'h0, vecs[i].exp_leds});
      end

      // 4: mask upper digits, slot timing unchanged
      bus_write(3'b001, 16'h000F);
      dark_hits = 0;
      prev_en = seg_en;
      for (int i = 0; i < 140; i++) begin
         cycle();
         if (seg_en[7:4] != 4'hF) dark_hits++;
         if (seg_en == 8'hFE && prev_en == 8'hFF) starts.push_back(cyc);
         prev_en = seg_en;
      end
      check("t4_masked_dark", dark_hits, 0);
      if (starts.size() < 2) check("t4_starts", starts.size(), 2);
      else check("t4_period", starts[1] - starts[0], 64);

      // 5: write to the lit digit mid-slot
      bus_write(3'b001, 16'h00FF);
      bus_write(3'b100, 16'h0000);
      wait_start(8'hFE, 80, found);
      check("t5_found", {31'h0, found}, 32'h1);
      bus_write(3'b100, 16'h0007);
      check("t5_old_out", {24'h0, seg_out}, 32'h0000_00C0);
      check("t5_old_en", {24'h0, seg_en}, 32'h0000_00FE);
      cycle();
      check("t5_new_out", {24'h0, seg_out}, 32'h0000_00F8);
      check("t5_new_en", {24'h0, seg_en}, 32'h0000_00FE);

      // 6: reset during slot 5
      wait_start(8'hDF, 80, found);
      check("t6_found", {31'h0, found}, 32'h1);
      cycle();
      do_reset();
      check_post_reset("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
